// File: rtl/alu_uart_interface.sv
// Byte-stream front end for the ALU: collects operand A, operand B and opcode from the
// receiver, latches the ALU result and issues one transmit request. Optional macro ALU_UART_TIMEOUT_EN.
module alu_uart_interface #(
  parameter int NBITS          = 8,
  parameter int COD_OP         = 6,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NBITS-1:0]  rx_data,
  input  logic              rx_done,
  input  logic [NBITS-1:0]  alu_result,
  input  logic              tx_busy,
  output logic [NBITS-1:0]  operando_A,
  output logic [NBITS-1:0]  operando_B,
  output logic [COD_OP-1:0] cod_operacion,
  output logic [NBITS-1:0]  tx_data,
  output logic              tx_start
);

  localparam logic [2:0] WAIT_A  = 3'd0;
  localparam logic [2:0] WAIT_B  = 3'd1;
  localparam logic [2:0] WAIT_OP = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;

  generate
    if (COD_OP > NBITS || COD_OP < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("alu_uart_interface: illegal parameter combination");
    end
  endgenerate

  logic [2:0]        state_q, state_d;
  logic [NBITS-1:0]  op_a_q, op_a_d;
  logic [NBITS-1:0]  op_b_q, op_b_d;
  logic [COD_OP-1:0] cod_q, cod_d;
  logic [NBITS-1:0]  tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;

`ifdef ALU_UART_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_expired;

  assign tmo_expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    cod_d      = cod_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
`ifdef ALU_UART_TIMEOUT_EN
    tmo_d      = '0;
`endif
    case (state_q)
      WAIT_A: begin
        if (rx_done) begin
          op_a_d  = rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rx_done) begin
          op_b_d  = rx_data;
          state_d = WAIT_OP;
        end else begin
`ifdef ALU_UART_TIMEOUT_EN
          if (tmo_expired) state_d = WAIT_A;
          else             tmo_d   = tmo_q + TW'(1);
`endif
        end
      end
      WAIT_OP: begin
        if (rx_done) begin
          cod_d   = rx_data[COD_OP-1:0];
          state_d = EXEC;
        end else begin
`ifdef ALU_UART_TIMEOUT_EN
          if (tmo_expired) state_d = WAIT_A;
          else             tmo_d   = tmo_q + TW'(1);
`endif
        end
      end
      // Operand registers have been stable for a full cycle, so the ALU output is settled.
      EXEC: begin
        tx_data_d = alu_result;
        state_d   = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = WAIT_A;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_A;
      op_a_q     <= '0;
      op_b_q     <= '0;
      cod_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
`ifdef ALU_UART_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      cod_q      <= cod_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
`ifdef ALU_UART_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign operando_A    = op_a_q;
  assign operando_B    = op_b_q;
  assign cod_operacion = cod_q;
  assign tx_data       = tx_data_q;
  assign tx_start      = tx_start_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface with a frame-level reference model and per-cycle compare.
module tb_alu_uart_interface;

  localparam int TMO = 16;
`ifdef ALU_UART_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] alu_result;
  logic       tx_busy;
  logic [7:0] operando_A;
  logic [7:0] operando_B;
  logic [5:0] cod_operacion;
  logic [7:0] tx_data;
  logic       tx_start;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_uart_interface #(
    .NBITS(8),
    .COD_OP(6),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .alu_result(alu_result),
    .tx_busy(tx_busy),
    .operando_A(operando_A),
    .operando_B(operando_B),
    .cod_operacion(cod_operacion),
    .tx_data(tx_data),
    .tx_start(tx_start)
  );

  // MIPS-style ALU stand-in; undefined opcodes give all ones.
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 8'hFF;
    endcase
  endfunction

  assign alu_result = alu_fn(operando_A, operando_B, cod_operacion);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: count of bytes collected, pending result, pending send.
  logic [7:0] exp_a = '0, exp_b = '0, exp_tx = '0;
  logic [5:0] exp_op = '0;
  logic       exp_start = 1'b0;
  int         m_n = 0, m_idle = 0;
  bit         m_exec = 1'b0, m_send = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_a <= '0; exp_b <= '0; exp_op <= '0; exp_tx <= '0; exp_start <= 1'b0;
      m_n <= 0; m_idle <= 0; m_exec <= 1'b0; m_send <= 1'b0;
    end else begin
      exp_start <= 1'b0;
      if (m_send) begin
        if (!tx_busy) begin
          m_send    <= 1'b0;
          exp_start <= 1'b1;
        end
      end else if (m_exec) begin
        exp_tx <= alu_fn(exp_a, exp_b, exp_op);
        m_exec <= 1'b0;
        m_send <= 1'b1;
      end else if (rx_done) begin
        m_idle <= 0;
        if (m_n == 0) begin
          exp_a <= rx_data; m_n <= 1;
        end else if (m_n == 1) begin
          exp_b <= rx_data; m_n <= 2;
        end else begin
          exp_op <= rx_data[5:0]; m_n <= 0; m_exec <= 1'b1;
        end
      end else if (m_n != 0) begin
        if (TMO_ON && m_idle == TMO - 1) begin
          m_n <= 0; m_idle <= 0;
        end else begin
          m_idle <= m_idle + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_operando_A", 32'(operando_A), 32'(exp_a));
    check("cyc_operando_B", 32'(operando_B), 32'(exp_b));
    check("cyc_cod_operacion", 32'(cod_operacion), 32'(exp_op));
    check("cyc_tx_data", 32'(tx_data), 32'(exp_tx));
    check("cyc_tx_start", 32'(tx_start), 32'(exp_start));
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a);
    send_byte(b);
    send_byte(op);
  endtask

  // Called right after the opcode sample edge k.
  task automatic expect_result(input string nm, input logic [7:0] exp);
    @(negedge clk);
    check({nm, "_tx_data"}, 32'(tx_data), 32'(exp));
    check({nm, "_start_k1"}, 32'(tx_start), 32'd0);
    @(negedge clk);
    check({nm, "_start_k2"}, 32'(tx_start), 32'd1);
    @(negedge clk);
    check({nm, "_start_k3"}, 32'(tx_start), 32'd0);
  endtask

  task automatic expect_all_zero(input string nm);
    check({nm, "_A"}, 32'(operando_A), 32'd0);
    check({nm, "_B"}, 32'(operando_B), 32'd0);
    check({nm, "_op"}, 32'(cod_operacion), 32'd0);
    check({nm, "_tx"}, 32'(tx_data), 32'd0);
    check({nm, "_start"}, 32'(tx_start), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    expect_all_zero("reset");
    #2 rst_n = 1'b1;

    // ADD
    send_frame(8'h05, 8'h03, 8'h20);
    check("add_A", 32'(operando_A), 32'h05);
    check("add_B", 32'(operando_B), 32'h03);
    check("add_op", 32'(cod_operacion), 32'h20);
    expect_result("add", 8'h08);

    // SUB with wrap
    send_frame(8'h03, 8'h05, 8'h22);
    expect_result("sub", 8'hFE);

    // Upper opcode bits masked, then undefined opcode
    send_frame(8'h10, 8'h01, 8'hE0);
    check("mask_op", 32'(cod_operacion), 32'h20);
    expect_result("mask", 8'h11);
    send_frame(8'h10, 8'h01, 8'h3F);
    check("undef_op", 32'(cod_operacion), 32'h3F);
    expect_result("undef", 8'hFF);

    // Backpressure: tx_busy high for 10 cycles from EXEC, stray byte dropped in SEND
    tx_busy = 1'b1;
    send_frame(8'h11, 8'h22, 8'h20);
    send_byte(8'h77);
    check("bp_start_a", 32'(tx_start), 32'd0);
    repeat (7) begin
      @(negedge clk);
      check("bp_start_held", 32'(tx_start), 32'd0);
    end
    check("bp_A_kept", 32'(operando_A), 32'h11);
    check("bp_tx", 32'(tx_data), 32'h33);
    tx_busy = 1'b0;
    @(negedge clk);
    check("bp_start_pulse", 32'(tx_start), 32'd1);
    @(negedge clk);
    check("bp_start_after", 32'(tx_start), 32'd0);

    // Reset mid-frame
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 expect_all_zero("midrst");
    repeat (2) @(negedge clk);
    expect_all_zero("midrst_hold");
    #2 rst_n = 1'b1;
    send_frame(8'h01, 8'h02, 8'h20);
    expect_result("post_rst", 8'h03);

`ifdef ALU_UART_TIMEOUT_EN
    send_byte(8'h09);
    repeat (20) @(negedge clk);
    send_frame(8'h04, 8'h06, 8'h24);
    check("tmo_A", 32'(operando_A), 32'h04);
    check("tmo_B", 32'(operando_B), 32'h06);
    expect_result("tmo", 8'h04);
`else
    send_byte(8'h09);
    repeat (20) @(negedge clk);
    send_byte(8'h04);
    send_byte(8'h24);
    check("idle_A", 32'(operando_A), 32'h09);
    check("idle_B", 32'(operando_B), 32'h04);
    expect_result("idle", 8'h00);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_uart_interface.md
Name: alu_uart_interface

Overview:
- Front-end controller that feeds the ALU from a byte-stream receiver and returns the ALU result to a byte-stream transmitter.
- Collects three received bytes in order: operand A, operand B, opcode. Drives the ALU operand and opcode inputs, captures the combinational result and issues it as one transmit request.
- Sits between the UART RX/TX pair and the ALU in the top-level datapath.

Parameters:
- NBITS, 8, data width of operands, result and RX/TX bytes.
- COD_OP, 6, opcode width. Must satisfy COD_OP <= NBITS.
- TIMEOUT_CYCLES, 50000, idle cycles allowed between bytes before the partial frame is discarded. Used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_data  input  NBITS  received byte. Valid only when rx_done=1.
- rx_done  input  1  one-cycle pulse marking a received byte.
- alu_result  input  NBITS  combinational result returned by the ALU.
- tx_busy  input  1  transmitter busy. A transmit request is legal only when this is 0.
- operando_A  output  NBITS  registered operand A to the ALU.
- operando_B  output  NBITS  registered operand B to the ALU.
- cod_operacion  output  COD_OP  registered opcode to the ALU.
- tx_data  output  NBITS  registered byte to transmit.
- tx_start  output  1  one-cycle transmit request pulse.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=WAIT_A.
  - operando_A, operando_B, cod_operacion, tx_data = 0.
  - tx_start = 0.
  - timeout counter = 0.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND.
- WAIT_A: at a clock edge with rx_done=1, operando_A <= rx_data and state <= WAIT_B.
- WAIT_B: at a clock edge with rx_done=1, operando_B <= rx_data and state <= WAIT_OP.
- WAIT_OP: at a clock edge with rx_done=1, cod_operacion <= rx_data[COD_OP-1:0] and state <= EXEC. Upper opcode bits are ignored.
- EXEC: lasts exactly one cycle. The ALU inputs are stable here, so tx_data <= alu_result and state <= SEND.
- SEND:
  - If tx_busy=0 at the edge: tx_start <= 1 for exactly one cycle and state <= WAIT_A.
  - If tx_busy=1: stay in SEND with tx_start=0, waiting indefinitely.
- tx_start is 0 in every cycle other than the one following the SEND exit edge.
- Latency: the opcode byte is sampled at edge k. tx_data is valid after edge k+1. tx_start is high in the cycle after edge k+2, provided tx_busy=0 at edge k+2.
- rx_done in EXEC or SEND: the byte is dropped and no register changes. The next frame starts with the first rx_done seen in WAIT_A.
- rx_done in the same cycle as tx_start=1 (state already WAIT_A): accepted as the new operand A.
- operando_A, operando_B and cod_operacion hold their values until overwritten by the next frame. tx_data holds until the next EXEC.
- Operands are passed unmodified. All arithmetic and opcode decoding belong to the ALU, including the all-ones result for undefined opcodes.
- Reset asserted mid-frame or in SEND: immediate return to reset values. No pending tx_start survives.

Optional Feature:
- Macro: ALU_UART_TIMEOUT_EN.
- Defined:
  - A counter clears on every accepted byte and on entry to WAIT_A.
  - It increments every cycle spent in WAIT_B or WAIT_OP.
  - When it reaches TIMEOUT_CYCLES-1 without rx_done, the next edge forces state <= WAIT_A and the counter clears.
  - Operand registers keep their stale values. No transmit occurs.
  - rx_done on the expiry edge wins: the byte is accepted normally.
- Not defined:
  - No counter is synthesized.
  - WAIT_B and WAIT_OP wait indefinitely.

Test Plan:
- ADD: bytes 0x05, 0x03, 0x20, tx_busy=0. Required: operando_A=0x05, operando_B=0x03, cod_operacion=0x20. tx_data=0x08. A single tx_start pulse exactly 2 cycles after the opcode sample edge.
- SUB with wrap: bytes 0x03, 0x05, 0x22. Required: tx_data=0xFE and one tx_start pulse.
- Opcode upper bits masked and undefined opcode:
  - Bytes 0x10, 0x01, 0xE0. Required: cod_operacion=0x20, tx_data=0x11.
  - Then bytes 0x10, 0x01, 0x3F. Required: tx_data=0xFF.
- Backpressure: tx_busy=1 held 10 cycles across EXEC. Required:
  - FSM stays in SEND and tx_start stays 0.
  - tx_start pulses once in the cycle after the first edge with tx_busy=0.
  - An rx_done of 0x77 during SEND is dropped: operando_A unchanged.
- Reset mid-frame: bytes 0xAA, 0xBB, then rst_n=0 for 2 cycles, then bytes 0x01, 0x02, 0x20. Required:
  - All outputs are 0 during reset.
  - The next frame yields tx_data=0x03.
- With ALU_UART_TIMEOUT_EN and TIMEOUT_CYCLES=16: byte 0x09, then 20 idle cycles, then bytes 0x04, 0x06, 0x24. Required:
  - The stale 0x09 is discarded and operando_A=0x04.
  - tx_data=0x04 (0x04 & 0x06).
